// File: rtl/uart_pkg.sv
// Shared UART definitions: ESC byte, parity modes, FSM state type and parity helper.
package uart_pkg;

  localparam logic [7:0] ESC      = 8'h1B;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Parity bit for a zero-extended payload; 0 when parity is disabled.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic ones_odd;
    ones_odd = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~ones_odd;
      PAR_EVEN: parity_bit = ones_odd;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_acc.sv
// Fractional phase accumulator: ticks on average BAUD_RATE times per CLK_RATE cycles.
// Held at zero while disabled so every frame starts from the same phase.
module uart_baud_acc #(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic en,
  output logic tick
);

  localparam int ACC_W = $clog2(CLK_RATE + BAUD_RATE);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic [ACC_W-1:0] acc_nxt_s;

  // Next phase and tick: wrap by CLK_RATE once the sum reaches it.
  always_comb begin
    sum_s     = acc_r + ACC_W'(BAUD_RATE);
    tick      = 1'b0;
    acc_nxt_s = '0;
    if (!en) begin
      acc_nxt_s = '0;
    end else if (sum_s >= ACC_W'(CLK_RATE)) begin
      tick      = 1'b1;
      acc_nxt_s = sum_s - ACC_W'(CLK_RATE);
    end else begin
      acc_nxt_s = sum_s;
    end
  end

  // Phase register with async reset and synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (srst) begin
      acc_r <= '0;
    end else begin
      acc_r <= acc_nxt_s;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with fractional baud timing and pass-through mux.
// Optional ESC/RESUME pause frames are built when UART_TX_FRAME_PAUSE_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int         CLK_RATE  = 100_000_000,
  parameter int         BAUD_RATE = 115200,
  parameter int         DATA_BITS = 8,
  parameter int         PARITY    = 0,
  parameter int         STOP_BITS = 1,
  parameter logic [7:0] RESUME    = 8'h00
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 TX_START_I,
  input  logic [DATA_BITS-1:0] DATA_I,
  output logic                 TX_DONE_O,
  output logic                 TX_BUSY_O,
  input  logic                 SEND_PAUSE_I,
  input  logic                 ESC_DETECTED_I,
  input  logic                 CHANNEL_I,
  input  logic                 TX1_I,
  output logic                 TX0_O
);

  localparam int PAR_W     = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_LEN = 1 + DATA_BITS + PAR_W + STOP_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  state_t               state_r, state_nxt_s;
  logic [FRAME_LEN-1:0] shift_r, shift_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic                 user_r, user_nxt_s;
  logic                 tick_s;
  logic                 done_s;
  logic                 busy_s;

`ifdef UART_TX_FRAME_PAUSE_EN
  logic pausing_r, pausing_nxt_s;
  logic last_esc_r, last_esc_nxt_s;

  if (DATA_BITS != 8) begin : g_pause_width_chk
    $error("uart_tx_frame: pause frames require DATA_BITS == 8");
  end
`else
  logic pause_unused_s;
  assign pause_unused_s = SEND_PAUSE_I | ESC_DETECTED_I;
`endif

  // Line image of a whole frame, bit 0 first: start, payload, parity, stops.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_LEN-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      f[1+i] = d[i];
    end
    f[1+DATA_BITS] = (PAR_W == 1) ? parity_bit(8'(d), 2'(PARITY)) : 1'b1;
    return f;
  endfunction

  assign busy_s = (state_r == SEND);

  uart_baud_acc #(
    .CLK_RATE  (CLK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud (
    .clk   (CLK_I),
    .rst_n (RST_NI),
    .srst  (CHANNEL_I),
    .en    (busy_s),
    .tick  (tick_s)
  );

  // Next-state logic: IDLE arbitrates pause events over user data, SEND shifts on ticks.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    user_nxt_s  = user_r;
    done_s      = 1'b0;
`ifdef UART_TX_FRAME_PAUSE_EN
    pausing_nxt_s  = pausing_r;
    last_esc_nxt_s = last_esc_r;
`endif
    case (state_r)
      IDLE: begin
`ifdef UART_TX_FRAME_PAUSE_EN
        if (SEND_PAUSE_I && !pausing_r) begin
          pausing_nxt_s = 1'b1;
          if (!last_esc_r) begin
            state_nxt_s = SEND;
            shift_nxt_s = build_frame(DATA_BITS'(ESC));
            cnt_nxt_s   = '0;
            user_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (!SEND_PAUSE_I && pausing_r) begin
          pausing_nxt_s = 1'b0;
          if (!last_esc_r) begin
            state_nxt_s = SEND;
            shift_nxt_s = build_frame(DATA_BITS'(RESUME));
            cnt_nxt_s   = '0;
            user_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (TX_START_I) begin
          last_esc_nxt_s = ESC_DETECTED_I;
          state_nxt_s    = SEND;
          shift_nxt_s    = build_frame(DATA_I);
          cnt_nxt_s      = '0;
          user_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
`else
        if (TX_START_I) begin
          state_nxt_s = SEND;
          shift_nxt_s = build_frame(DATA_I);
          cnt_nxt_s   = '0;
          user_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
`endif
      end
      SEND: begin
        if (tick_s) begin
          shift_nxt_s = {1'b1, shift_r[FRAME_LEN-1:1]};
          if (cnt_r == LAST_BIT) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            done_s      = user_r;
            user_nxt_s  = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register; pass-through mode clears it like reset.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_r <= IDLE;
    end else if (CHANNEL_I) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame shifter, bit counter and pause bookkeeping.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      shift_r <= '1;
      cnt_r   <= '0;
      user_r  <= 1'b0;
`ifdef UART_TX_FRAME_PAUSE_EN
      pausing_r  <= 1'b0;
      last_esc_r <= 1'b0;
`endif
    end else if (CHANNEL_I) begin
      shift_r <= '1;
      cnt_r   <= '0;
      user_r  <= 1'b0;
`ifdef UART_TX_FRAME_PAUSE_EN
      pausing_r  <= 1'b0;
      last_esc_r <= 1'b0;
`endif
    end else begin
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      user_r  <= user_nxt_s;
`ifdef UART_TX_FRAME_PAUSE_EN
      pausing_r  <= pausing_nxt_s;
      last_esc_r <= last_esc_nxt_s;
`endif
    end
  end

  assign TX_BUSY_O = busy_s;
  assign TX_DONE_O = done_s & ~CHANNEL_I;
  assign TX0_O     = CHANNEL_I ? TX1_I : shift_r[0];

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 debug-link transmitter. Serialises a word of configurable width with optional parity and one or two stop bits. Baud timing comes from a fractional phase accumulator, so the average bit period is exact for any clock/baud ratio. The block sits between the debug-transport FSM and the shared TX pin, keeps the pass-through channel mux, and optionally inserts ESC/RESUME pause frames.

## Interface
- CLK_RATE, 100_000_000: system clock in Hz.
- BAUD_RATE, 115200: line rate in bit/s; must be ≤ CLK_RATE/2.
- DATA_BITS, 8: payload width, 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- RESUME, 8'h00: byte sent when a pause ends.
- CLK_I  in  1  system clock.
- RST_NI  in  1  reset; asynchronous, active-low.
- TX_START_I  in  1  request to send DATA_I; sampled only in IDLE.
- DATA_I  in  DATA_BITS  payload, sent LSB first.
- TX_DONE_O  out  1  one-cycle pulse at the end of a user-data frame.
- TX_BUSY_O  out  1  high while a frame is in progress.
- SEND_PAUSE_I  in  1  level; the rising condition sends ESC, the falling condition sends RESUME.
- ESC_DETECTED_I  in  1  qualifies DATA_I as an ESC byte; sampled with TX_START_I.
- CHANNEL_I  in  1  1 = pass TX1_I through; 0 = this transmitter drives the line.
- TX1_I  in  1  alternate serial source.
- TX0_O  out  1  serial line output.

## Operation
- Reset values: state IDLE, tx=1, TX_BUSY_O=0, TX_DONE_O=0, pausing=0, last_esc=0, accumulator=0.
- TX0_O = CHANNEL_I ? TX1_I : tx.
- CHANNEL_I=1 synchronously clears the FSM as reset does, aborting any frame; no TX_DONE_O is issued.
- Frame, LSB first: start(0), DATA_BITS payload, parity bit if PARITY≠0, then STOP_BITS ones. Length is 1+DATA_BITS+(PARITY≠0)+STOP_BITS.
- Parity: odd makes the count of ones in payload plus parity odd; even makes it even.
- FSM states are IDLE and SEND. TX_BUSY_O = (state==SEND).
- IDLE priority, highest first:
  - SEND_PAUSE_I && !pausing: set pausing; if !last_esc, send an ESC frame.
  - !SEND_PAUSE_I && pausing: clear pausing; if !last_esc, send a RESUME frame.
  - TX_START_I: latch last_esc=ESC_DETECTED_I and send DATA_I.
- TX_START_I while busy is ignored, with no queueing. The requester holds the request until it sees TX_DONE_O.
- Baud generator: the accumulator width is clog2(CLK_RATE+BAUD_RATE). Each SEND cycle it computes s=acc+BAUD_RATE.
  - If s≥CLK_RATE: assert tick and set acc=s−CLK_RATE.
  - Otherwise: acc=s.
  - acc is forced to 0 in IDLE.

## Timing
- A request accepted at clock edge T loads the frame. The start bit appears on TX0_O from cycle T+1.
- Bit i is held from cycle S_i to the tick cycle inclusive. Each hold is floor or ceil of CLK_RATE/BAUD_RATE cycles, and the long-run average is exact.
- TX_DONE_O is high during the final cycle of the last stop bit, and only for frames started by TX_START_I. ESC and RESUME frames give no pulse.
- TX_BUSY_O falls in the cycle after TX_DONE_O. A new TX_START_I is accepted in that cycle, so back-to-back frames have zero idle bits.
- Pause events that arrive while busy are serviced in the first IDLE cycle, ahead of TX_START_I.
- Asynchronous reset mid-frame: TX0_O returns to 1 (when CHANNEL_I=0) immediately and no TX_DONE_O is issued.

## Configuration
- UART_TX_FRAME_PAUSE_EN defined: pause/ESC/RESUME logic is present. An elaboration assertion requires DATA_BITS==8. ESC comes from uart_pkg.
- Not defined: SEND_PAUSE_I and ESC_DETECTED_I are ignored. pausing and last_esc are removed. Only TX_START_I launches frames.

## Structure
- uart_pkg holds ESC, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the state_t enum shared with the receiver successor.
- Sub-module uart_baud_acc contains the fractional phase accumulator, with enable input and tick output. It is reused by the receiver.

## Test plan
- CLK_RATE=1_000_000, BAUD_RATE=300_000, 8N1, DATA_I=8'hA5 → line 0,1,0,1,0,0,1,0,1,1; bit lengths 4,3,3,4,3,3,… cycles; TX_DONE_O pulses once.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, DATA_I=7'h03 → 0,1,1,0,0,0,0,0, parity 1, stop 1,1; 11 bit periods total.
- PARITY=2 with DATA_I=8'hFF → parity bit 0; with DATA_I=8'h01 → parity bit 1.
- Pause: raise SEND_PAUSE_I mid-frame → after the current frame, ESC frame with no TX_DONE_O. Drop SEND_PAUSE_I → RESUME 8'h00 frame. Repeat after sending DATA_I=ESC with ESC_DETECTED_I=1 → no ESC/RESUME frames.
- TX_START_I held continuously over three words → zero-gap frames, three TX_DONE_O pulses, TX_BUSY_O low for exactly one cycle between frames.
- CHANNEL_I=1 mid-frame → TX0_O follows TX1_I next cycle and no TX_DONE_O. Return to 0 → TX0_O=1 and FSM in IDLE.
